// File: rtl/udp_tx_pkg.sv
// Shared types and header constants for the UDP transmit scheduler and related arbiters.
package udp_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  localparam logic [15:0] UDP_HDR_BYTES = 16'd8;
  localparam logic [15:0] IP_HDR_BYTES  = 16'd20;

  localparam int DEF_MIN_PAYLOAD = 18;
  localparam int DEF_MAX_PAYLOAD = 1472;

endpackage

// File: rtl/udp_tx_sched_rr_pick.sv
// Combinational round-robin search: first set request strictly after the pointer, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_valid
);

  always_comb begin
    int k;
    k        = 0;
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(i_ptr) + i) % NUM_REQ;
      if (!o_valid && i_req[k[SEL_W-1:0]]) begin
        o_onehot[k[SEL_W-1:0]] = 1'b1;
        o_idx                  = k[SEL_W-1:0];
        o_valid                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_tx_sched.sv
// Round-robin scheduler sharing one UDP frame sender among NUM_REQ sources.
// Optional sender watchdog enabled by defining UDP_TX_SCHED_WDOG_EN.
import udp_tx_pkg::*;

module udp_tx_sched #(
  parameter int NUM_REQ     = 4,
  parameter int SEL_W       = 2,
  parameter int MIN_PAYLOAD = DEF_MIN_PAYLOAD,
  parameter int MAX_PAYLOAD = DEF_MAX_PAYLOAD,
  parameter int IFG_CYCLES  = 12,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*16-1:0] req_len,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic                  len_err,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [SEL_W-1:0]      tx_sel,
  output logic [15:0]           tx_data_length,
  output logic [15:0]           tx_total_length,
  output logic                  wdog_err
);

  localparam int     GAP_W       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam state_t AFTER_FRAME = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;

  if (NUM_REQ < 2 || NUM_REQ > 8 || SEL_W != $clog2(NUM_REQ) || WDOG_CYCLES < 1)
    begin : g_bad_param
      $error("udp_tx_sched: illegal parameter combination");
    end

  state_t               r_state;
  logic [SEL_W-1:0]     r_ptr;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_len_err;
  logic                 r_tx_start;
  logic [SEL_W-1:0]     r_tx_sel;
  logic [15:0]          r_data_len;
  logic [15:0]          r_total_len;
  logic [GAP_W-1:0]     r_gap_cnt;

  logic [NUM_REQ-1:0]   w_onehot;
  logic [SEL_W-1:0]     w_idx;
  logic                 w_any;
  logic [15:0]          w_len;
  logic                 w_len_bad;

  rr_pick #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W)) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_valid  (w_any)
  );

  always_comb begin
    w_len = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (w_idx == SEL_W'(k)) w_len = req_len[16*k +: 16];
  end

  assign w_len_bad = (w_len < 16'(MIN_PAYLOAD)) || (w_len > 16'(MAX_PAYLOAD));

`ifdef UDP_TX_SCHED_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] r_wdog_cnt;
  logic            r_wdog_err;
  logic            w_waiting;
  logic            w_leaving;
  assign w_waiting = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
  assign w_leaving = ((r_state == S_WAIT_BUSY) &&  tx_busy) ||
                     ((r_state == S_WAIT_DONE) && !tx_busy);
  assign wdog_err  = r_wdog_err;
`else
  assign wdog_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= SEL_W'(NUM_REQ - 1);
      r_gnt       <= '0;
      r_done      <= '0;
      r_len_err   <= 1'b0;
      r_tx_start  <= 1'b0;
      r_tx_sel    <= '0;
      r_data_len  <= '0;
      r_total_len <= '0;
      r_gap_cnt   <= '0;
`ifdef UDP_TX_SCHED_WDOG_EN
      r_wdog_cnt  <= '0;
      r_wdog_err  <= 1'b0;
`endif
    end else begin
      r_done     <= '0;
      r_len_err  <= 1'b0;
      r_tx_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_ptr <= w_idx;
            if (w_len_bad) begin
              r_len_err <= 1'b1;
              r_done    <= w_onehot;
            end else begin
              r_gnt       <= w_onehot;
              r_tx_sel    <= w_idx;
              r_data_len  <= w_len + UDP_HDR_BYTES;
              r_total_len <= w_len + UDP_HDR_BYTES + IP_HDR_BYTES;
              r_tx_start  <= 1'b1;
              r_state     <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH:    r_state <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (tx_busy) r_state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            r_done    <= r_gnt;
            r_gnt     <= '0;
            r_gap_cnt <= '0;
            r_state   <= AFTER_FRAME;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_W'(IFG_CYCLES - 1)) r_state <= S_IDLE;
          else r_gap_cnt <= r_gap_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef UDP_TX_SCHED_WDOG_EN
      // Later assignments here override the normal frame handling when the sender hangs.
      r_wdog_err <= 1'b0;
      if (!w_waiting || w_leaving) begin
        r_wdog_cnt <= '0;
      end else if (r_wdog_cnt == WD_W'(WDOG_CYCLES - 1)) begin
        r_wdog_err <= 1'b1;
        r_done     <= r_gnt;
        r_gnt      <= '0;
        r_gap_cnt  <= '0;
        r_wdog_cnt <= '0;
        r_state    <= AFTER_FRAME;
      end else begin
        r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end
`endif
    end
  end

  assign gnt             = r_gnt;
  assign done            = r_done;
  assign len_err         = r_len_err;
  assign tx_start        = r_tx_start;
  assign tx_sel          = r_tx_sel;
  assign tx_data_length  = r_data_len;
  assign tx_total_length = r_total_len;

endmodule

// File: tb/tb_udp_tx_sched.sv
// Self-checking bench for udp_tx_sched: bench acts as requesters and sender, with a rotation model.
module tb_udp_tx_sched;

  localparam int NREQ = 4;
  localparam int IFG  = 12;
  localparam int WDOG = 4096;
  localparam int MINP = 18;
  localparam int MAXP = 1472;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_len;
  logic        tx_busy;
  logic [3:0]  gnt, done;
  logic        len_err, tx_start, wdog_err;
  logic [1:0]  tx_sel;
  logic [15:0] tx_data_length, tx_total_length;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = NREQ - 1;
  int lens [NREQ];

  udp_tx_sched dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_len         (req_len),
    .gnt             (gnt),
    .done            (done),
    .len_err         (len_err),
    .tx_start        (tx_start),
    .tx_busy         (tx_busy),
    .tx_sel          (tx_sel),
    .tx_data_length  (tx_data_length),
    .tx_total_length (tx_total_length),
    .wdog_err        (wdog_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int k, input int v);
    lens[k] = v;
    req_len[16*k +: 16] = 16'(v);
  endtask

  // Spec rotation: first requester found searching upward from ptr+1 with wrap.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 1; i <= NREQ; i++) begin
      int k;
      k = (p + i) % NREQ;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  // Called just after the grant edge; returns just after the done edge.
  task automatic serve(input int busy_cycles);
    tick();
    tx_busy = 1'b1;
    repeat (busy_cycles) tick();
    tx_busy = 1'b0;
    tick();
  endtask

  task automatic wait_gnt(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (gnt == 4'b0 && !len_err && cycles < 200);
    if (cycles >= 200) cycles = -1;
  endtask

  task automatic drain();
    req     = '0;
    tx_busy = 1'b0;
    repeat (IFG + 3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; tx_busy = 1'b0; req_len = '0;
    tick(); tick();
    n_checks++; if (gnt !== 4'b0)  begin n_fail++; $display("FAIL rst_gnt got %b want 0000", gnt); end
    n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL rst_done got %b want 0000", done); end
    n_checks++; if (len_err !== 1'b0 || tx_start !== 1'b0 || wdog_err !== 1'b0)
      begin n_fail++; $display("FAIL rst_pulses got %b%b%b want 000", len_err, tx_start, wdog_err); end
    n_checks++; if (tx_sel !== 2'b0 || tx_data_length !== 16'd0 || tx_total_length !== 16'd0)
      begin n_fail++; $display("FAIL rst_lens got %0d/%0d/%0d want 0/0/0", tx_sel, tx_data_length, tx_total_length); end
    rst = 1'b0;
    m_ptr = NREQ - 1;
  endtask

  task automatic test_single();
    int c;
    set_len(0, 100);
    req = 4'b0001;
    tick();
    n_checks++; if (gnt !== 4'b0001 || tx_start !== 1'b1)
      begin n_fail++; $display("FAIL single_grant got gnt=%b start=%b want 0001/1", gnt, tx_start); end
    n_checks++; if (tx_data_length !== 16'd108 || tx_total_length !== 16'd128 || tx_sel !== 2'd0)
      begin n_fail++; $display("FAIL single_lens got %0d/%0d/%0d want 108/128/0", tx_data_length, tx_total_length, tx_sel); end
    m_ptr = 0;
    tick();
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_width got %b want 0", tx_start); end
    tx_busy = 1'b1;
    repeat (200) tick();
    n_checks++; if (done !== 4'b0 || gnt !== 4'b0001)
      begin n_fail++; $display("FAIL single_busy_hold got done=%b gnt=%b want 0000/0001", done, gnt); end
    tx_busy = 1'b0;
    tick();
    n_checks++; if (done !== 4'b0001 || gnt !== 4'b0)
      begin n_fail++; $display("FAIL single_done got done=%b gnt=%b want 0001/0000", done, gnt); end
    wait_gnt(c);
    n_checks++; if (c != IFG + 1)
      begin n_fail++; $display("FAIL single_gap got %0d cycles want %0d", c, IFG + 1); end
    serve(3);
    drain();
  endtask

  task automatic test_round_robin();
    int c, exp;
    rst = 1'b1; tick(); rst = 1'b0; m_ptr = NREQ - 1;
    set_len(0, 18); set_len(1, 64); set_len(2, 512); set_len(3, 1472);
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_gnt(c);
      exp = pick(req, m_ptr);
      n_checks++; if (c < 0 || gnt !== 4'(1 << exp) || !$onehot(gnt))
        begin n_fail++; $display("FAIL rr_order frame %0d got %b want %b", f, gnt, 4'(1 << exp)); end
      n_checks++; if (tx_data_length !== 16'(lens[exp] + 8) || tx_total_length !== 16'(lens[exp] + 28) || tx_sel !== 2'(exp))
        begin n_fail++; $display("FAIL rr_lens frame %0d got %0d/%0d/%0d want %0d/%0d/%0d", f,
          tx_data_length, tx_total_length, tx_sel, lens[exp] + 8, lens[exp] + 28, exp); end
      m_ptr = exp;
      serve($urandom_range(1, 10));
      n_checks++; if (done !== 4'(1 << exp) || gnt !== 4'b0)
        begin n_fail++; $display("FAIL rr_done frame %0d got %b want %b", f, done, 4'(1 << exp)); end
    end
    drain();
  endtask

  task automatic test_len_limits();
    int bad [2] = '{17, 1473};
    for (int i = 0; i < 2; i++) begin
      set_len(2, bad[i]);
      req = 4'b0100;
      tick();
      n_checks++; if (len_err !== 1'b1 || done !== 4'b0100 || gnt !== 4'b0 || tx_start !== 1'b0)
        begin n_fail++; $display("FAIL len_reject %0d got err=%b done=%b gnt=%b start=%b want 1/0100/0000/0",
          bad[i], len_err, done, gnt, tx_start); end
      m_ptr = 2;
      req = '0;
      tick();
      n_checks++; if (len_err !== 1'b0 || done !== 4'b0)
        begin n_fail++; $display("FAIL len_pulse_width got err=%b done=%b want 0/0000", len_err, done); end
    end
    set_len(2, MAXP);
    req = 4'b0100;
    tick();
    n_checks++; if (gnt !== 4'b0100 || tx_start !== 1'b1 || tx_total_length !== 16'd1500 || tx_data_length !== 16'd1480)
      begin n_fail++; $display("FAIL len_max got gnt=%b start=%b tot=%0d dat=%0d want 0100/1/1500/1480",
        gnt, tx_start, tx_total_length, tx_data_length); end
    m_ptr = 2;
    serve(2);
    n_checks++; if (done !== 4'b0100) begin n_fail++; $display("FAIL len_max_done got %b want 0100", done); end
    drain();
  endtask

  task automatic test_reset_mid();
    int c;
    set_len(0, 200); set_len(1, 300); set_len(2, 400); set_len(3, 500);
    req = 4'b1111;
    wait_gnt(c);
    tick();
    tx_busy = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    n_checks++; if (gnt !== 4'b0 || done !== 4'b0 || tx_start !== 1'b0 || len_err !== 1'b0)
      begin n_fail++; $display("FAIL midrst_outputs got gnt=%b done=%b start=%b err=%b want all 0", gnt, done, tx_start, len_err); end
    n_checks++; if (tx_data_length !== 16'd0 || tx_total_length !== 16'd0 || tx_sel !== 2'd0)
      begin n_fail++; $display("FAIL midrst_lens got %0d/%0d/%0d want 0/0/0", tx_data_length, tx_total_length, tx_sel); end
    tx_busy = 1'b0;
    tick();
    rst = 1'b0;
    m_ptr = NREQ - 1;
    tick();
    n_checks++; if (gnt !== 4'b0001 || done !== 4'b0)
      begin n_fail++; $display("FAIL midrst_first got gnt=%b done=%b want 0001/0000", gnt, done); end
    m_ptr = 0;
    serve(1);
    drain();
  endtask

  task automatic test_random();
    int c, exp;
    logic [3:0] r;
    r = 4'($urandom_range(1, 15));
    for (int k = 0; k < NREQ; k++) set_len(k, $urandom_range(0, 1600));
    req = r;
    for (int f = 0; f < 24; f++) begin
      wait_gnt(c);
      exp = pick(req, m_ptr);
      if (c < 0) begin
        n_checks++; n_fail++;
        $display("FAIL rand_timeout frame %0d got no grant want requester %0d", f, exp);
        break;
      end
      if (lens[exp] < MINP || lens[exp] > MAXP) begin
        n_checks++; if (len_err !== 1'b1 || done !== 4'(1 << exp) || gnt !== 4'b0)
          begin n_fail++; $display("FAIL rand_reject frame %0d len %0d got err=%b done=%b gnt=%b want 1/%b/0000",
            f, lens[exp], len_err, done, gnt, 4'(1 << exp)); end
      end else begin
        n_checks++; if (gnt !== 4'(1 << exp) || tx_sel !== 2'(exp) || tx_start !== 1'b1 ||
                        tx_data_length !== 16'(lens[exp] + 8) || tx_total_length !== 16'(lens[exp] + 28))
          begin n_fail++; $display("FAIL rand_grant frame %0d got gnt=%b sel=%0d dat=%0d tot=%0d want %b/%0d/%0d/%0d",
            f, gnt, tx_sel, tx_data_length, tx_total_length, 4'(1 << exp), exp, lens[exp] + 8, lens[exp] + 28); end
        serve($urandom_range(1, 6));
        n_checks++; if (done !== 4'(1 << exp) || gnt !== 4'b0)
          begin n_fail++; $display("FAIL rand_done frame %0d got done=%b gnt=%b want %b/0000", f, done, gnt, 4'(1 << exp)); end
      end
      m_ptr = exp;
      r = req & ~4'(1 << exp);
      r = r | 4'($urandom_range(0, 15));
      if (r == 4'b0) r = 4'b1000;
      set_len(exp, $urandom_range(0, 1600));
      req = r;
    end
    drain();
  endtask

`ifdef UDP_TX_SCHED_WDOG_EN
  task automatic test_wdog();
    int c;
    set_len(1, 64);
    req = 4'b0010;
    tick();
    m_ptr = 1;
    tick();
    tx_busy = 1'b1;
    tick();
    c = 0;
    do begin
      tick();
      c++;
    end while (!wdog_err && c < WDOG + 10);
    n_checks++; if (c != WDOG)
      begin n_fail++; $display("FAIL wdog_time got %0d want %0d", c, WDOG); end
    n_checks++; if (done !== 4'b0010 || gnt !== 4'b0)
      begin n_fail++; $display("FAIL wdog_done got done=%b gnt=%b want 0010/0000", done, gnt); end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_len_limits();
    test_reset_mid();
    test_random();
`ifdef UDP_TX_SCHED_WDOG_EN
    test_wdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_tx_sched.md
Name: udp_tx_sched

Overview:
- Round-robin scheduler that shares one GMII UDP frame sender among NUM_REQ payload sources.
- Picks a ready requester and drives the sender's length inputs and payload-RAM select, then pulses the sender start.
- Tracks the sender's busy flag to completion, enforces a minimum inter-frame gap, and returns a done pulse to the winner.
- Sits between the per-source payload RAMs and the UDP send engine, in the same clock domain as the sender.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SEL_W, 2, width of tx_sel; equals clog2(NUM_REQ).
- MIN_PAYLOAD, 18, smallest accepted UDP payload in bytes.
- MAX_PAYLOAD, 1472, largest accepted UDP payload in bytes.
- IFG_CYCLES, 12, idle cycles enforced after sender busy falls (0 allowed).
- WDOG_CYCLES, 4096, watchdog limit (optional feature only).

Ports:
- clk  in  1  tx clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level, requester k has a frame ready.
- req_len  in  NUM_REQ*16  payload byte count, slice k = [16k+15:16k].
- gnt  out  NUM_REQ  one-hot grant, held for the whole frame.
- done  out  NUM_REQ  one-cycle completion pulse to requester k.
- len_err  out  1  one-cycle pulse, length rejected.
- tx_start  out  1  one-cycle start pulse to the sender.
- tx_busy  in  1  sender not in idle.
- tx_sel  out  SEL_W  payload RAM mux select.
- tx_data_length  out  16  UDP length = payload + 8.
- tx_total_length  out  16  IP total length = payload + 28.
- wdog_err  out  1  one-cycle pulse, sender hung (optional feature only; tied 0 without it).

Behaviour:
- Reset values:
  - Every output is 0 and state = IDLE.
  - The round-robin pointer is NUM_REQ-1, so requester 0 wins first.
  - Reset mid-frame drops gnt immediately and issues no done.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If any req bit is set, the winner is the first set bit searching upward from pointer+1, with modulo wrap.
  - Pointer is updated to the winner.
  - Winner's req_len checked against MIN_PAYLOAD..MAX_PAYLOAD:
    - Out of range: pulse len_err and done[winner] on the next edge, no gnt, no tx_start, remain IDLE. The next arbitration starts the cycle after.
    - In range: on the next edge register gnt, tx_sel, and the lengths, then go to LAUNCH.
  - Length arithmetic is 16-bit. It cannot overflow because len ≤ MAX_PAYLOAD.
- LAUNCH: tx_start = 1 for exactly one cycle, then go to WAIT_BUSY.
  - Latency: req sampled at edge N gives gnt at N+1 and tx_start high between edges N+1 and N+2.
- WAIT_BUSY: wait for tx_busy = 1, then go to WAIT_DONE.
- WAIT_DONE: on tx_busy = 0:
  - pulse done[winner] for one cycle;
  - clear gnt in the same edge;
  - go to GAP.
- GAP:
  - Count IFG_CYCLES cycles with no arbitration, then go to IDLE.
  - If IFG_CYCLES = 0, go directly to IDLE.
- Lengths and tx_sel stay stable from the gnt edge until done. The sender may sample them at any time while busy.
- Requester rules:
  - A requester deasserting req while granted is ignored; the frame completes and done still pulses.
  - req must remain high until done; the requester clears it on done.
  - A req rising in the same cycle IDLE arbitrates is eligible.
- A single requester continuously asserting req is re-granted after every gap. This is fairness by rotation only.
- At most one bit of gnt and at most one bit of done is ever set.

Optional Feature:
- Macro: UDP_TX_SCHED_WDOG_EN.
- Defined: a counter runs in WAIT_BUSY and WAIT_DONE. On reaching WDOG_CYCLES:
  - pulse wdog_err and done[winner];
  - clear gnt;
  - go to GAP.
  - The counter clears on every state entry.
- Undefined: no counter is built, wdog_err is tied 0, and the block waits indefinitely.

Decomposition:
- Shared package udp_tx_pkg holds:
  - state enum;
  - constants UDP_HDR_BYTES = 8 and IP_HDR_BYTES = 20;
  - default MIN_PAYLOAD and MAX_PAYLOAD.
- One sub-module: rr_pick.
  - Combinational round-robin priority search.
  - Inputs: req, pointer. Outputs: one-hot winner and index.
  - Reused by future RX-side arbiters.

Test Plan:
1. Single request: req = 0001, len = 100 → gnt = 0001 at N+1; tx_data_length = 108, tx_total_length = 128, tx_sel = 0; tx_start one cycle; busy 200 cycles → done[0] pulse; gnt low; 12 idle cycles before next grant.
2. All four requesting continuously with lengths 18/64/512/1472 → grant order 0,1,2,3,0; every frame's lengths match its source; no two gnt bits ever set.
3. Length limits:
   - req[2] with len = 17 → len_err and done[2] pulse, no tx_start.
   - len = 1473 → same response.
   - len = 1472 → accepted, total = 1500.
4. Assert rst while in WAIT_DONE → all outputs 0 next edge; after release, requester 0 wins first even if req = 1111.
5. IFG_CYCLES = 0 build: back-to-back frames from requesters 1 and 3 → second gnt asserted the edge after GAP→IDLE, one cycle after done.
6. With UDP_TX_SCHED_WDOG_EN and WDOG_CYCLES = 64: tx_busy held high → wdog_err and done pulse at cycle 64 of WAIT_DONE; next requester then granted.
